// File: rtl/disp_scanner.sv
// disp_scanner: multiplexed 4-digit common-anode 7-segment display driver.
// Captures {s1, s0} into a shadow register once per refresh frame and scans
// it as four hex digits. Each digit slot begins with a guard interval that
// turns all anodes off to suppress ghosting.
//
// Optional feature macro: DISP_LZB_EN compiles in leading-zero blanking.
//
// Parameters:
//   CLK_DIV   - clock cycles per digit slot (>= 2)
//   GUARD_CYC - all-anodes-off cycles at the start of each slot (< CLK_DIV)
// Ports:
//   clk    - system clock
//   reset  - synchronous, active-high reset
//   s0     - CPU output port 0, digits 1 (s0[7:4]) and 0 (s0[3:0])
//   s1     - CPU output port 1, digits 3 (s1[7:4]) and 2 (s1[3:0])
//   frz    - freeze: shadow register holds while high
//   an     - anode enables, active-low, one-hot (registered)
//   seg    - segments {g,f,e,d,c,b,a}, active-low (registered)
//   frame  - one-cycle pulse after each frame-boundary evaluation (registered)
module disp_scanner #(
    parameter int unsigned CLK_DIV   = 50000,
    parameter int unsigned GUARD_CYC = 500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] s0,
    input  logic [7:0] s1,
    input  logic       frz,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       frame
);

    localparam int unsigned CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GC_LAST = CNT_W'((GUARD_CYC > 0) ? GUARD_CYC - 1 : 0);
    localparam bit NO_GUARD = (GUARD_CYC == 0);

    typedef enum logic {GUARD, DRIVE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] gc, gc_nxt;
    logic [1:0]       idx;
    logic [15:0]      shd;
    logic             tick_c;
    logic [3:0]       nib_c;
    logic [3:0]       an_nxt;
    logic [6:0]       seg_nxt;

    // Hex font, active-low {g,f,e,d,c,b,a}
    function automatic logic [6:0] font(input logic [3:0] n);
        case (n)
            4'h0: font = 7'h40;
            4'h1: font = 7'h79;
            4'h2: font = 7'h24;
            4'h3: font = 7'h30;
            4'h4: font = 7'h19;
            4'h5: font = 7'h12;
            4'h6: font = 7'h02;
            4'h7: font = 7'h78;
            4'h8: font = 7'h00;
            4'h9: font = 7'h10;
            4'hA: font = 7'h08;
            4'hB: font = 7'h03;
            4'hC: font = 7'h46;
            4'hD: font = 7'h21;
            4'hE: font = 7'h06;
            default: font = 7'h0E;
        endcase
    endfunction

    assign tick_c = (cnt == CNT_MAX);

    // Nibble of the shadow register for the current digit
    always_comb begin
        case (idx)
            2'd0:    nib_c = shd[3:0];
            2'd1:    nib_c = shd[7:4];
            2'd2:    nib_c = shd[11:8];
            default: nib_c = shd[15:12];
        endcase
    end

`ifdef DISP_LZB_EN
    logic blank_c;

    // Digit i blanks when nibbles i..3 are all zero; digit 0 always shows
    always_comb begin
        case (idx)
            2'd1:    blank_c = (shd[15:4] == 12'h000);
            2'd2:    blank_c = (shd[15:8] == 8'h00);
            2'd3:    blank_c = (shd[15:12] == 4'h0);
            default: blank_c = 1'b0;
        endcase
    end
`endif

    // Guard/drive state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= GUARD;
            gc    <= '0;
        end else begin
            state <= state_nxt;
            gc    <= gc_nxt;
        end
    end

    // Next state and next display outputs
    always_comb begin
        state_nxt = state;
        gc_nxt    = gc;
        an_nxt    = 4'b1111;
        seg_nxt   = 7'h7F;

        if (tick_c) begin
            state_nxt = NO_GUARD ? DRIVE : GUARD;
            gc_nxt    = '0;
        end else if (state == GUARD) begin
            gc_nxt = gc + CNT_W'(1);
            if (NO_GUARD || gc == GC_LAST) begin
                state_nxt = DRIVE;
            end
        end

        // With no guard interval the GUARD state is never visible
        if (state == DRIVE || NO_GUARD) begin
            an_nxt = ~(4'b0001 << idx);
`ifdef DISP_LZB_EN
            seg_nxt = blank_c ? 7'h7F : font(nib_c);
`else
            seg_nxt = font(nib_c);
`endif
        end
    end

    // Prescaler, digit index, shadow capture and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            idx   <= 2'd0;
            shd   <= 16'h0000;
            an    <= 4'b1111;
            seg   <= 7'h7F;
            frame <= 1'b0;
        end else begin
            cnt   <= tick_c ? '0 : cnt + CNT_W'(1);
            an    <= an_nxt;
            seg   <= seg_nxt;
            frame <= tick_c && (idx == 2'd3);
            if (tick_c) begin
                idx <= idx + 2'd1;
            end
            if (tick_c && idx == 2'd3 && !frz) begin
                shd <= {s1, s0};
            end
        end
    end

endmodule

// File: tb/tb_disp_scanner.sv
// tb_disp_scanner: directed self-checking bench for disp_scanner with
// CLK_DIV=4, GUARD_CYC=1. Every slot is one guard cycle (an=1111) followed
// by three drive cycles; outputs are sampled 1 ns after each rising edge.
module tb_disp_scanner;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] s0;
    logic [7:0] s1;
    logic       frz;
    logic [3:0] an;
    logic [6:0] seg;
    logic       frame;

    int checks = 0;
    int errors = 0;

    disp_scanner #(.CLK_DIV(4), .GUARD_CYC(1)) dut (
        .clk   (clk),
        .reset (reset),
        .s0    (s0),
        .s1    (s1),
        .frz   (frz),
        .an    (an),
        .seg   (seg),
        .frame (frame)
    );

    always #5 clk = ~clk;

    // One clock, then compare all three outputs
    task automatic cyc(input logic [3:0] ea, input logic [6:0] es, input logic ef, input string tag);
        @(posedge clk);
        #1;
        checks++;
        assert (an === ea) else begin
            errors++;
            $error("FAIL %s an=%b expected %b", tag, an, ea);
        end
        checks++;
        assert (seg === es) else begin
            errors++;
            $error("FAIL %s seg=%h expected %h", tag, seg, es);
        end
        checks++;
        assert (frame === ef) else begin
            errors++;
            $error("FAIL %s frame=%b expected %b", tag, frame, ef);
        end
    endtask

    // One digit slot: guard cycle then three drive cycles; frame on the last
    // drive cycle of slot 3
    task automatic do_slot(input int i, input logic [6:0] es, input string tag);
        logic [3:0] ea;
        case (i)
            0:       ea = 4'b1110;
            1:       ea = 4'b1101;
            2:       ea = 4'b1011;
            default: ea = 4'b0111;
        endcase
        cyc(4'b1111, 7'h7F, 1'b0, {tag, "_guard"});
        cyc(ea, es, 1'b0, {tag, "_drv"});
        cyc(ea, es, 1'b0, {tag, "_drv"});
        cyc(ea, es, (i == 3), {tag, "_drv_end"});
    endtask

    task automatic do_frame(input logic [6:0] e0, input logic [6:0] e1,
                            input logic [6:0] e2, input logic [6:0] e3, input string tag);
        do_slot(0, e0, tag);
        do_slot(1, e1, tag);
        do_slot(2, e2, tag);
        do_slot(3, e3, tag);
    endtask

    initial begin
        reset = 1'b1;
        s1    = 8'hFF;
        s0    = 8'h00;
        frz   = 1'b0;

        // Reset held for three cycles
        cyc(4'b1111, 7'h7F, 1'b0, "reset0");
        cyc(4'b1111, 7'h7F, 1'b0, "reset1");
        cyc(4'b1111, 7'h7F, 1'b0, "reset2");

        // First frame shows shd=0; frame pulses on the 16th edge after release
        reset = 1'b0;
        s1    = 8'h12;
        s0    = 8'h34;
        do_frame(7'h40, 7'h40, 7'h40, 7'h40, "first");

        // Basic scan of 1234; s0 changes mid-frame without tearing
        do_slot(0, 7'h19, "scan");
        do_slot(1, 7'h30, "scan");
        s0 = 8'hAB;
        do_slot(2, 7'h24, "tear");
        do_slot(3, 7'h79, "tear");

        // 12AB appears; freeze asserted with new data before the boundary
        do_slot(0, 7'h03, "upd");
        do_slot(1, 7'h08, "upd");
        do_slot(2, 7'h24, "upd");
        frz = 1'b1;
        s1  = 8'h78;
        s0  = 8'h56;
        do_slot(3, 7'h79, "upd");

        // Frozen frame keeps 12AB; release freeze mid-frame
        do_slot(0, 7'h03, "frz");
        do_slot(1, 7'h08, "frz");
        frz = 1'b0;
        do_slot(2, 7'h24, "frz");
        do_slot(3, 7'h79, "frz");

        // 7856 appears one frame after release
        do_frame(7'h02, 7'h12, 7'h00, 7'h78, "unfrz");

        // Reset during slot 2
        do_slot(0, 7'h02, "pre_rst");
        do_slot(1, 7'h12, "pre_rst");
        cyc(4'b1111, 7'h7F, 1'b0, "pre_rst_guard");
        cyc(4'b1011, 7'h00, 1'b0, "pre_rst_drv");
        reset = 1'b1;
        cyc(4'b1111, 7'h7F, 1'b0, "midrst");
        reset = 1'b0;
        do_frame(7'h40, 7'h40, 7'h40, 7'h40, "post_rst");
        do_slot(0, 7'h02, "relatch");
        s1 = 8'h00;
        s0 = 8'h05;
        do_slot(1, 7'h12, "relatch");
        do_slot(2, 7'h00, "relatch");
        do_slot(3, 7'h78, "relatch");

        // Leading zeros: blanked when compiled in, decoded as 0 otherwise
`ifdef DISP_LZB_EN
        do_slot(0, 7'h12, "lzb05");
        s0 = 8'h00;
        do_slot(1, 7'h7F, "lzb05");
        do_slot(2, 7'h7F, "lzb05");
        do_slot(3, 7'h7F, "lzb05");
        do_frame(7'h40, 7'h7F, 7'h7F, 7'h7F, "lzb00");
`else
        do_slot(0, 7'h12, "zero05");
        s0 = 8'h00;
        do_slot(1, 7'h40, "zero05");
        do_slot(2, 7'h40, "zero05");
        do_slot(3, 7'h40, "zero05");
        do_frame(7'h40, 7'h40, 7'h40, 7'h40, "zero00");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
